// File: rtl/twos_to_signmag.sv
// twos_to_signmag: converts a 32-bit two's-complement operand into sign and
// 31-bit magnitude. Non-negative operands resolve in one cycle; negative
// operands are negated bit-serially (LSB first, copy through the first 1,
// then invert) over 32 BUSY cycles. Result is held until the consumer takes it.
module twos_to_signmag (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sign,
    output logic [30:0] magnitude,
    output logic        overflow,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_shift;     // operand bits still to be processed, LSB next
    logic [30:0] r_res;       // serial result bits produced so far, newest on top
    logic [4:0]  r_cnt;       // number of bits already processed
    logic        r_seen;      // a 1 has already been copied; invert from now on
    logic        r_sign;
    logic [30:0] r_mag;
    logic        r_ovf;

    logic        w_accept;
    logic        w_last;
    logic        w_res_bit;
    logic [31:0] w_res_full;

    assign w_accept   = in_valid && (r_state == IDLE);
    assign w_last     = (r_cnt == 5'd31);
    assign w_res_bit  = r_seen ? ~r_shift[0] : r_shift[0];
    // After the 32nd step this holds the whole negated operand, bit 0 at the bottom.
    assign w_res_full = {w_res_bit, r_res};

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign busy       = (r_state == BUSY);
    assign sign       = r_sign;
    assign magnitude  = r_mag;
    assign overflow   = r_ovf;

    // State register; reset aborts any operation in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept only in IDLE, drain result only in DONE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = in[31] ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: latch operand on accept, run the serial negate while BUSY,
    // and leave outputs untouched while waiting in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_seen  <= 1'b0;
            r_sign  <= 1'b0;
            r_mag   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift <= in;
                        r_sign  <= in[31];
                        r_cnt   <= '0;
                        r_seen  <= 1'b0;
                        r_res   <= '0;
                        r_ovf   <= 1'b0;
                        // Negative operands get their magnitude at the end of BUSY.
                        r_mag   <= in[31] ? 31'd0 : in[30:0];
                    end
                end
                BUSY: begin
                    r_shift <= {1'b0, r_shift[31:1]};
                    r_res   <= w_res_full[31:1];
                    r_seen  <= r_seen | r_shift[0];
                    // Hold at 31 on the final step so the counter never wraps.
                    r_cnt   <= w_last ? r_cnt : r_cnt + 5'd1;
                    if (w_last) begin
                        r_mag <= w_res_full[30:0];
                        r_ovf <= w_res_full[31];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/twos_to_signmag.md
TWOS_TO_SIGNMAG -- requirements
Module: twos_to_signmag

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-004 in_valid  input  1  in carries a 32-bit two's-complement operand.
REQ-005 in_ready  output  1  block can accept an operand this cycle.
REQ-006 in  input  32  two's-complement operand; sampled only on an accept.
REQ-007 out_valid  output  1  sign/magnitude/overflow hold a result.
REQ-008 out_ready  input  1  consumer takes the result this cycle.
REQ-009 sign  output  1  sign of the accepted operand: 1 = negative.
REQ-010 magnitude  output  31  absolute value of the operand, unsigned.
REQ-011 overflow  output  1  magnitude is not representable in 31 bits (operand 32'h80000000).
REQ-012 busy  output  1  block is in state BUSY.

Function
REQ-013 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; an accept is the condition in_valid && in_ready at a clk edge.
REQ-015 On an accept, the block SHALL latch in into a 32-bit shift register, and sign SHALL take in[31].
REQ-016 On an accept with in[31]=0, the FSM SHALL go to DONE with magnitude=in[30:0] and overflow=0, so out_valid is high one cycle after the accept.
REQ-017 On an accept with in[31]=1, the FSM SHALL go to BUSY, clear the 5-bit bit counter and clear the seen_one flag.
REQ-018 Each BUSY cycle SHALL process one operand bit, LSB first:
- result bit = seen_one ? ~b : b;
- seen_one |= b;
- the counter increments.
REQ-019 This processing is the serial negate rule: copy up to and including the first 1, then invert.
REQ-020 After the BUSY cycle with counter=31 (32 BUSY cycles), the FSM SHALL go to DONE.
REQ-021 On entry to DONE from BUSY, with r the 32-bit serial result:
- magnitude SHALL be r[30:0];
- overflow SHALL be r[31].
REQ-022 For a negative operand, an accept at edge 0 SHALL give out_valid high from cycle 33 (latency 33 cycles).
REQ-023 Operand 0 SHALL take the positive path: sign=0, magnitude=0, overflow=0, latency 1.
REQ-024 Operand 32'h80000000 SHALL produce sign=1, magnitude=31'h0, overflow=1.
REQ-025 out_valid SHALL be 1 only in DONE.
REQ-026 sign, magnitude and overflow SHALL stay stable while out_valid=1 and out_ready=0 (back-pressure of any length).
REQ-027 On out_valid && out_ready, the FSM SHALL return to IDLE, with in_ready=1 in the next cycle.
REQ-028 There SHALL be no accept in the same cycle as that return, so throughput is at most one result every 2 cycles (positive) or every 34 cycles (negative).
REQ-029 in and in_valid SHALL be ignored outside IDLE; changing in during BUSY SHALL NOT affect the result.
REQ-030 out_ready SHALL be ignored outside DONE.
REQ-031 busy SHALL be 1 exactly in BUSY.
REQ-032 The counter SHALL NOT wrap beyond 31 within one operation.

Reset
REQ-033 On reset=1 at a clk edge, the FSM SHALL go to IDLE regardless of state, aborting any BUSY or DONE operation with no result delivered.
REQ-034 After reset, the outputs SHALL be: in_ready=1, out_valid=0, busy=0, sign=0, magnitude=0, overflow=0; the counter, seen_one and the shift register SHALL be 0.
REQ-035 reset SHALL take priority over a simultaneous accept or output handshake.
REQ-036 An operand presented during reset SHALL NOT be accepted.

Verification
REQ-037 Positive operand: in=32'h00000005, accept at cycle 0, out_ready=1 -> cycle 1: out_valid=1, sign=0, magnitude=5, overflow=0; cycle 2: in_ready=1.
REQ-038 Negative operands, one case per operand:
- in=32'hFFFFFFFF -> busy=1 for cycles 1-32; cycle 33: out_valid=1, sign=1, magnitude=1, overflow=0.
- in=32'h80000001 -> cycle 33: sign=1, magnitude=31'h7FFFFFFF, overflow=0.
REQ-039 Extremes: in=32'h80000000 -> sign=1, magnitude=0, overflow=1; in=0 -> cycle 1: sign=0, magnitude=0, overflow=0.
REQ-040 Back-pressure:
- in=32'hFFFFFF9C (-100) with out_ready=0 for 10 cycles after out_valid -> sign=1, magnitude=100 held constant, in_ready=0 throughout;
- out_ready=1 -> next cycle in_ready=1.
REQ-041 Input changes while busy: in changes every cycle while busy=1 -> the result equals the magnitude of the operand latched at the accept.
REQ-042 Reset mid-BUSY:
- reset=1 at BUSY cycle 10 -> next cycle: IDLE, in_ready=1, out_valid=0, all outputs 0;
- in_valid=1 held during reset -> no accept.
